// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI initiator: command encodings, FSM states and frame layout.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_W = 11;

  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, READ, GAP} spi_state_e;

  // The top type bit is doubled so the slave sees its read/write select first.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] cmd_type,
                                                    input logic [7:0] cmd_data);
    return {cmd_type[1], cmd_type, cmd_data};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bus of the SPI initiator.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [DATA_W-1:0] cmd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises one 11-bit command frame per handshake and, for read-data
// commands, collects the returned byte from MISO.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 0,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.slave  bus,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);
  import spi_pkg::*;

  // One counter serves bit, wait and gap counting; widen it only if a parameter needs it.
  localparam int CNT_LIM = (GAP > RD_WAIT) ? GAP : RD_WAIT;
  localparam int CNT_W   = (CNT_LIM > 15) ? $clog2(CNT_LIM) : 4;

  spi_state_e          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [FRAME_W-1:0]  tx_reg;
  logic [DATA_W-2:0]   rx_reg;
  logic [1:0]          type_reg;
  logic                ss_n_reg;
  logic                mosi_reg;
  logic                ready_reg;
  logic                busy_reg;
  logic                rd_valid_reg;
  logic [DATA_W-1:0]   rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      type_reg     <= '0;
      ss_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid && ready_reg) begin
            tx_reg    <= make_frame(bus.cmd_type, bus.cmd_data);
            type_reg  <= bus.cmd_type;
            state_reg <= START;
            ss_n_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end

        START: begin
          state_reg <= SHIFT;
          mosi_reg  <= tx_reg[FRAME_W-1];
          tx_reg    <= {tx_reg[FRAME_W-2:0], 1'b0};
          cnt_reg   <= CNT_W'(FRAME_W - 1);
        end

        SHIFT: begin
          if (cnt_reg != '0) begin
            mosi_reg <= tx_reg[FRAME_W-1];
            tx_reg   <= {tx_reg[FRAME_W-2:0], 1'b0};
            cnt_reg  <= cnt_reg - CNT_W'(1);
          end else begin
            mosi_reg <= 1'b0;
            if (type_reg == CMD_RD_DATA) begin
              if (RD_WAIT > 0) begin
                state_reg <= WAIT;
                cnt_reg   <= CNT_W'(RD_WAIT - 1);
              end else begin
                state_reg <= READ;
                cnt_reg   <= CNT_W'(DATA_W - 1);
              end
            end else begin
              state_reg <= spi_pkg::GAP;
              ss_n_reg  <= 1'b1;
              cnt_reg   <= CNT_W'(GAP - 1);
            end
          end
        end

        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= READ;
            cnt_reg   <= CNT_W'(DATA_W - 1);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        // rd_data is only written once the whole byte is in, so it holds between reads.
        READ: begin
          rx_reg <= {rx_reg[DATA_W-3:0], MISO};
          if (cnt_reg == '0) begin
            rd_data_reg  <= {rx_reg, MISO};
            rd_valid_reg <= 1'b1;
            ss_n_reg     <= 1'b1;
            state_reg    <= spi_pkg::GAP;
            cnt_reg      <= CNT_W'(GAP - 1);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        spi_pkg::GAP: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          ss_n_reg  <= 1'b1;
          mosi_reg  <= 1'b0;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.rd_data   = rd_data_reg;
  assign busy          = busy_reg;
  assign SS_n          = ss_n_reg;
  assign MOSI          = mosi_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: the bench plays the SPI slave + RAM and checks framing,
// timing and returned data for an RD_WAIT=0/GAP=1 build and an RD_WAIT=2/GAP=3 build.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int RDW1 = 2;
  localparam int GAP0 = 1;
  localparam int GAP1 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       miso;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         last_rise = 0;

  // Slave-side reference: address register, RAM contents and last byte each DUT returned.
  logic [7:0] mem [256];
  logic [7:0] addr_m;
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl_if #(.DATA_W(8)) bus0 ();
  spi_master_ctrl_if #(.DATA_W(8)) bus1 ();

  wire ss0, mosi0, busy0, ss1, mosi1, busy1;

  assign bus0.cmd_valid = cmd_valid & ~sel;
  assign bus0.cmd_type  = cmd_type;
  assign bus0.cmd_data  = cmd_data;
  assign bus1.cmd_valid = cmd_valid & sel;
  assign bus1.cmd_type  = cmd_type;
  assign bus1.cmd_data  = cmd_data;

  spi_master_ctrl #(.DATA_W(8), .RD_WAIT(0), .GAP(GAP0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .SS_n(ss0), .MOSI(mosi0), .MISO(miso)
  );

  spi_master_ctrl #(.DATA_W(8), .RD_WAIT(RDW1), .GAP(GAP1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .SS_n(ss1), .MOSI(mosi1), .MISO(miso)
  );

  wire       m_ss    = sel ? ss1 : ss0;
  wire       m_mosi  = sel ? mosi1 : mosi0;
  wire       m_busy  = sel ? busy1 : busy0;
  wire       m_ready = sel ? bus1.cmd_ready : bus0.cmd_ready;
  wire       m_rdv   = sel ? bus1.rd_valid : bus0.rd_valid;
  wire [7:0] m_rdd   = sel ? bus1.rd_data : bus0.rd_data;

  // Runs one command on the selected DUT. Starts and ends on a falling edge with the DUT idle.
  task automatic do_cmd(input logic [1:0] t, input logic [7:0] d, input bit hold, input bit chk_b2b);
    int rdw, gapn, idx, k, acc_cyc, low_exp, bad, bad_gap;
    logic [10:0] frame;
    logic [7:0]  rd_byte;
    logic        exp_mosi;
    bit          is_rd, ok;
    rdw     = sel ? RDW1 : 0;
    gapn    = sel ? GAP1 : GAP0;
    is_rd   = (t == CMD_RD_DATA);
    frame   = {t[1], t[1], t[0], d};
    rd_byte = mem[addr_m];
    low_exp = is_rd ? 20 + rdw : 12;
    cmd_type  = t;
    cmd_data  = d;
    cmd_valid = 1'b1;

    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (m_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin
      $display("FAIL accept_timeout: cmd_ready=%b, required 1 within 64 cycles", m_ready);
      n_fail++;
      cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (chk_b2b) begin
      n_tests++;
      if (acc_cyc - last_rise !== gapn + 1) begin
        $display("FAIL b2b_accept_delay: got %0d cycles after SS_n rise, required %0d",
                 acc_cyc - last_rise, gapn + 1);
        n_fail++;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;

    idx = 0;
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (m_ss !== 1'b0) break;
      exp_mosi = (idx >= 1 && idx <= 11) ? frame[11 - idx] : 1'b0;
      if (m_mosi !== exp_mosi) bad++;
      if (m_rdv !== 1'b0 || m_ready !== 1'b0 || m_busy !== 1'b1) bad++;
      k = idx - (12 + rdw);
      miso = (is_rd && k >= 0 && k < 8) ? rd_byte[7 - k] : 1'($urandom);
      idx++;
    end
    n_tests++;
    if (m_ss !== 1'b1) begin
      $display("FAIL frame_timeout: SS_n=%b, required 1 within 64 cycles", m_ss);
      n_fail++;
      return;
    end
    n_tests++;
    if (idx !== low_exp) begin
      $display("FAIL ss_low_len: cmd=%0d got %0d cycles, required %0d", t, idx, low_exp);
      n_fail++;
    end
    n_tests++;
    if (bad !== 0) begin
      $display("FAIL frame_bits: cmd=%0d data=%02h got %0d bad cycles, required 0", t, d, bad);
      n_fail++;
    end
    n_tests++;
    if (m_rdv !== is_rd) begin
      $display("FAIL rd_valid_pulse: got %b, required %b", m_rdv, is_rd);
      n_fail++;
    end
    if (is_rd) begin
      last_rd[int'(sel)] = rd_byte;
      n_tests++;
      if (m_rdd !== rd_byte) begin
        $display("FAIL rd_data: got %02h, required %02h", m_rdd, rd_byte);
        n_fail++;
      end
    end
    last_rise = cyc;

    bad_gap = 0;
    if (m_mosi !== 1'b0 || m_ready !== 1'b0 || m_busy !== 1'b1) bad_gap++;
    for (int g = 1; g < gapn; g++) begin
      @(negedge clk);
      if (m_ss !== 1'b1 || m_mosi !== 1'b0 || m_rdv !== 1'b0 || m_ready !== 1'b0 || m_busy !== 1'b1)
        bad_gap++;
    end
    n_tests++;
    if (bad_gap !== 0) begin
      $display("FAIL gap_state: got %0d bad gap cycles, required 0", bad_gap);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (m_ready !== 1'b1 || m_busy !== 1'b0 || m_rdd !== last_rd[int'(sel)]) begin
      $display("FAIL idle_after_gap: ready=%b busy=%b rd_data=%02h, required 1 0 %02h",
               m_ready, m_busy, m_rdd, last_rd[int'(sel)]);
      n_fail++;
    end

    case (t)
      CMD_WR_ADDR: addr_m = d;
      CMD_WR_DATA: mem[addr_m] = d;
      CMD_RD_ADDR: addr_m = d;
      default: ;
    endcase
    $display("[TB] dut%0d cmd=%0d data=%02h ss_low=%0d rd_data=%02h", sel, t, d, idx, m_rdd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b0;
    cmd_valid = 1'b0;
    cmd_type = 2'b00;
    cmd_data = 8'h00;
    miso = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ss0 !== 1'b1 || mosi0 !== 1'b0 || busy0 !== 1'b0 || bus0.cmd_ready !== 1'b1 ||
        bus0.rd_valid !== 1'b0 || bus0.rd_data !== 8'h00) begin
      $display("FAIL reset_dut0: ss=%b mosi=%b busy=%b ready=%b rdv=%b rdd=%02h, required 1 0 0 1 0 00",
               ss0, mosi0, busy0, bus0.cmd_ready, bus0.rd_valid, bus0.rd_data);
      n_fail++;
    end
    n_tests++;
    if (ss1 !== 1'b1 || mosi1 !== 1'b0 || busy1 !== 1'b0 || bus1.cmd_ready !== 1'b1 ||
        bus1.rd_valid !== 1'b0 || bus1.rd_data !== 8'h00) begin
      $display("FAIL reset_dut1: ss=%b mosi=%b busy=%b ready=%b rdv=%b rdd=%02h, required 1 0 0 1 0 00",
               ss1, mosi1, busy1, bus1.cmd_ready, bus1.rd_valid, bus1.rd_data);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    sel = 1'b0;
    cmd_type = CMD_RD_DATA;
    cmd_data = 8'($urandom);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (16) @(negedge clk);
    n_tests++;
    if (m_ss !== 1'b0) begin
      $display("FAIL mid_frame_active: SS_n=%b, required 0", m_ss);
      n_fail++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (m_ss !== 1'b1 || m_mosi !== 1'b0 || m_rdv !== 1'b0 || m_busy !== 1'b0) begin
        $display("FAIL in_reset: ss=%b mosi=%b rdv=%b busy=%b, required 1 0 0 0",
                 m_ss, m_mosi, m_rdv, m_busy);
        n_fail++;
      end
    end
    rst = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    n_tests++;
    if (m_ready !== 1'b1 || m_ss !== 1'b1 || m_rdd !== 8'h00) begin
      $display("FAIL after_reset: ready=%b ss=%b rdd=%02h, required 1 1 00", m_ready, m_ss, m_rdd);
      n_fail++;
    end
    pulses = 0;
    repeat (24) begin
      @(negedge clk);
      if (m_rdv !== 1'b0 || m_ss !== 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      $display("FAIL abandoned_frame: got %0d active cycles after reset, required 0", pulses);
      n_fail++;
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    do_cmd(CMD_WR_ADDR, 8'hA5, 1'b0, 1'b0);
    do_cmd(CMD_WR_DATA, 8'h3C, 1'b0, 1'b0);
    do_cmd(CMD_RD_ADDR, 8'hA5, 1'b0, 1'b0);
    do_cmd(CMD_RD_DATA, 8'h00, 1'b0, 1'b0);
    n_tests++;
    if (m_rdd !== 8'h3C) begin
      $display("FAIL directed_readback: got %02h, required 3c", m_rdd);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 4; i++)
        do_cmd(2'($urandom_range(0, 3)), 8'($urandom), (i < 3), (i > 0));
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_rd_wait();
    sel = 1'b1;
    mem[8'h10] = 8'hC3;
    do_cmd(CMD_RD_ADDR, 8'h10, 1'b0, 1'b0);
    do_cmd(CMD_RD_DATA, 8'($urandom), 1'b0, 1'b0);
    n_tests++;
    if (m_rdd !== 8'hC3) begin
      $display("FAIL rd_wait_readback: got %02h, required c3", m_rdd);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [7:0] d;
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      t = 2'($urandom_range(0, 3));
      d = (t == CMD_WR_ADDR || t == CMD_RD_ADDR) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_cmd(t, d, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    addr_m = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    test_reset();
    test_reset_mid_frame();
    test_directed();
    test_back_to_back();
    test_rd_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
